// File: rtl/iopad_arb_pkg.sv
// Shared types and constants for the iopad bank direction arbiter.
package iopad_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TURN = 2'd2,
    TX   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_RX = 1'b0,
    OWN_TX = 1'b1
  } owner_e;

  // iopad direction convention: 1 = pad drives din (hi-Z), 0 = dout drives pad.
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/iopad_turn_timer.sv
// Loadable down-counter timing the hi-Z turnaround gap; done marks the last gap cycle.
module iopad_turn_timer #(
  parameter int TURN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(TURN_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/iopad_dir_arbiter.sv
// TX/RX arbiter for one iopad bank with hi-Z turnaround gaps around every TX ownership.
// Optional statistics counters are enabled with `define IOPAD_ARB_STATS_EN.
module iopad_dir_arbiter
  import iopad_arb_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_req,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_grant,
  input  logic             rx_req,
  output logic             rx_grant,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] pad_dout,
  input  logic [WIDTH-1:0] pad_din,
  output logic [WIDTH-1:0] pad_direction
`ifdef IOPAD_ARB_STATS_EN
  ,
  output logic [15:0]      turn_count,
  output logic [15:0]      preempt_count
`endif
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_e          state_q, state_d;
  state_e          target_q, target_d;
  owner_e          last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [WIDTH-1:0] rx_data_q;
  logic            rx_valid_q;
  logic            burst_max;
  logic            turn_start;
  logic            turn_done;
  logic            preempt;
  logic            enter_rx;
  logic            enter_tx;

  iopad_turn_timer #(
    .TURN_CYCLES(TURN_CYCLES)
  ) u_turn_timer (
    .clk  (clk),
    .rst  (rst),
    .start(turn_start),
    .done (turn_done)
  );

  assign burst_max = (burst_q == BW'(MAX_BURST - 1));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    preempt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that did not own the bank last goes first.
        if (rx_req && (!tx_req || last_q == OWN_TX)) begin
          state_d = RX;
        end else if (tx_req) begin
          state_d  = TURN;
          target_d = TX;
        end
      end
      RX: begin
        if (!rx_req) begin
          state_d = IDLE;
        end else if (burst_max && tx_req) begin
          state_d  = TURN;
          target_d = TX;
          preempt  = 1'b1;
        end
      end
      TX: begin
        if (!tx_req) begin
          state_d  = TURN;
          target_d = IDLE;
        end else if (burst_max && rx_req) begin
          state_d  = TURN;
          target_d = IDLE;
          preempt  = 1'b1;
        end
      end
      TURN: begin
        if (turn_done) begin
          state_d = target_q;
        end
      end
      default: state_d = IDLE;
    endcase

    turn_start = (state_d == TURN) && (state_q != TURN);
    enter_rx   = (state_d == RX) && (state_q != RX);
    enter_tx   = (state_d == TX) && (state_q != TX);

    last_d = last_q;
    if (enter_rx) begin
      last_d = OWN_RX;
    end else if (enter_tx) begin
      last_d = OWN_TX;
    end

    // Saturating at MAX_BURST-1 lets a lone owner keep the bank indefinitely.
    burst_d = burst_q;
    if (enter_rx || enter_tx) begin
      burst_d = '0;
    end else if ((state_q == RX || state_q == TX) && !burst_max) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= IDLE;
      last_q     <= OWN_TX;
      burst_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      rx_valid_q <= rx_grant && rx_req;
      if (rx_grant && rx_req) begin
        rx_data_q <= pad_din;
      end
    end
  end

  assign tx_grant      = (state_q == TX);
  assign rx_grant      = (state_q == RX);
  assign pad_direction = {WIDTH{(state_q == TX) ? DIR_OUT : DIR_IN}};
  assign pad_dout      = (tx_grant && tx_req) ? tx_data : '0;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;

`ifdef IOPAD_ARB_STATS_EN
  logic [15:0] turn_cnt_q;
  logic [15:0] preempt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_cnt_q    <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (turn_start) begin
        turn_cnt_q <= sat_inc16(turn_cnt_q);
      end
      if (preempt) begin
        preempt_cnt_q <= sat_inc16(preempt_cnt_q);
      end
    end
  end

  assign turn_count    = turn_cnt_q;
  assign preempt_count = preempt_cnt_q;
`endif

endmodule
